// File: rtl/conv3x3_mac_engine.sv
// Sequential 3x3 signed multiply-accumulate engine with a writable, snapshotted kernel.
// Define MAC_SAT_EN to clamp out-of-range results instead of wrapping them.
module conv3x3_mac_engine #(
    parameter int M          = 3,
    parameter int N          = 3,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(M*N) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           win_valid,
    output logic                           win_ready,
    input  logic [M*N*DATA_WIDTH-1:0]      win_data,
    input  logic [DATA_WIDTH-1:0]          coef_in,
    input  logic [$clog2(M*N)-1:0]         coef_addr,
    input  logic                           coef_wen,
    output logic [2*DATA_WIDTH-1:0]        matrix_result,
    output logic                           matrix_valid,
    output logic                           overflow,
    output logic                           busy
);

    localparam int TAPS = M * N;
    localparam int AW   = $clog2(TAPS);
    localparam int RW   = 2 * DATA_WIDTH;
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic [RW-1:0] RES_MAX  = {1'b0, {(RW-1){1'b1}}};
    localparam logic [RW-1:0] RES_MIN  = {1'b1, {(RW-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                        state_q;
    logic signed [DATA_WIDTH-1:0]  coef_mem [TAPS];
    logic signed [DATA_WIDTH-1:0]  kern_q   [TAPS];
    logic signed [DATA_WIDTH-1:0]  pix_q    [TAPS];
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic [AW-1:0]                 tap_q;

    logic signed [RW-1:0]          pix_ext;
    logic signed [RW-1:0]          coef_ext;
    logic signed [RW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic [ACC_WIDTH-RW:0]         acc_top;
    logic                          acc_fits;
    logic [RW-1:0]                 res_narrow;

    // Sobel-X, row-major; the middle row carries weight 2.
    function automatic logic signed [DATA_WIDTH-1:0] sobel_x(input int k);
        int row;
        int col;
        int mag;
        row = k / N;
        col = k % N;
        mag = (row == M / 2) ? 2 : 1;
        if (col == 0) begin
            return DATA_WIDTH'(-mag);
        end else if (col == N - 1) begin
            return DATA_WIDTH'(mag);
        end
        return '0;
    endfunction

    always_comb begin
        pix_ext  = {{DATA_WIDTH{pix_q[tap_q][DATA_WIDTH-1]}}, pix_q[tap_q]};
        coef_ext = {{DATA_WIDTH{kern_q[tap_q][DATA_WIDTH-1]}}, kern_q[tap_q]};
        prod     = pix_ext * coef_ext;
        acc_next = acc_q + {{(ACC_WIDTH-RW){prod[RW-1]}}, prod};
        // Fits in RW signed bits iff all bits above the RW-1 sign bit agree with it.
        acc_top  = acc_next[ACC_WIDTH-1:RW-1];
        acc_fits = (&acc_top) | ~(|acc_top);
`ifdef MAC_SAT_EN
        if (acc_fits) begin
            res_narrow = acc_next[RW-1:0];
        end else begin
            res_narrow = acc_next[ACC_WIDTH-1] ? RES_MIN : RES_MAX;
        end
`else
        res_narrow = acc_next[RW-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            win_ready     <= 1'b1;
            busy          <= 1'b0;
            matrix_valid  <= 1'b0;
            matrix_result <= '0;
            overflow      <= 1'b0;
            acc_q         <= '0;
            tap_q         <= '0;
            for (int k = 0; k < TAPS; k++) begin
                coef_mem[k] <= sobel_x(k);
            end
        end else begin
            if (coef_wen && coef_addr <= LAST_TAP) begin
                coef_mem[coef_addr] <= coef_in;
            end
            matrix_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        // Snapshot reads the pre-edge memory, so a same-cycle write is not seen.
                        for (int k = 0; k < TAPS; k++) begin
                            pix_q[k]  <= win_data[k*DATA_WIDTH +: DATA_WIDTH];
                            kern_q[k] <= coef_mem[k];
                        end
                        acc_q     <= '0;
                        tap_q     <= '0;
                        win_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_next;
                    tap_q <= tap_q + AW'(1);
                    if (tap_q == LAST_TAP) begin
                        matrix_valid  <= 1'b1;
                        matrix_result <= res_narrow;
                        overflow      <= ~acc_fits;
                        state_q       <= StDone;
                    end
                end
                StDone: begin
                    win_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
